// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: FSM encodings, sample RAM
// geometry and the default trigger threshold.
package wave_pkg;

  localparam int unsigned WAVE_HALF_AW = 8;
  localparam int unsigned WAVE_AW      = 9;
  localparam int unsigned WAVE_DW      = 8;

  localparam logic [WAVE_DW-1:0] WAVE_TRIG_LEVEL = 8'd128;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } wave_state_e;

endpackage

// File: rtl/dffre.sv
// Resettable flop bank with load enable; reset is asynchronous and active-high.
module dffre #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/wave_trigger_detect.sv
// Rising-edge trigger detector: remembers the last accepted sample and flags an
// upward crossing of the threshold by the current sample.
module wave_trigger_detect
  import wave_pkg::*;
#(
  parameter logic [WAVE_DW-1:0] TRIG_LEVEL = WAVE_TRIG_LEVEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               accept,
  input  logic [WAVE_DW-1:0] sample_in,
  output logic               trig
);

  logic [WAVE_DW-1:0] prev_sample_q;
  logic [WAVE_DW-1:0] prev_sample_d;

  always_comb begin
    prev_sample_d = accept ? sample_in : prev_sample_q;
  end

  // Resets to the threshold so the very first sample cannot look like a crossing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sample_q <= TRIG_LEVEL;
    end else begin
      prev_sample_q <= prev_sample_d;
    end
  end

  assign trig = (prev_sample_q < TRIG_LEVEL) && (sample_in >= TRIG_LEVEL);

endmodule

// File: rtl/wave_capture_ctrl.sv
// Ping-pong write controller for the 512x8 waveform RAM: decimates samples,
// waits for a trigger, fills the hidden half and swaps halves on vsync.
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int unsigned        DECIM      = 1,
  parameter logic [WAVE_DW-1:0] TRIG_LEVEL = WAVE_TRIG_LEVEL,
  parameter int unsigned        TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_sample,
  input  logic [WAVE_DW-1:0] sample_in,
  input  logic               vsync,
  output logic               wr_en,
  output logic [WAVE_AW-1:0] wr_addr,
  output logic [WAVE_DW-1:0] wr_data,
  output logic               read_index,
  output logic [1:0]         state,
  output logic               frame_ready
);

  localparam int unsigned   TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [7:0]    D_LAST = 8'(DECIM - 1);

  wave_state_e              state_q, state_d;
  logic [WAVE_HALF_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic                     read_index_q, read_index_d;
  logic                     wr_en_q, wr_en_d;
  logic [WAVE_AW-1:0]       wr_addr_q, wr_addr_d;
  logic [WAVE_DW-1:0]       wr_data_q, wr_data_d;
  logic                     frame_ready_q, frame_ready_d;

  logic [7:0]    decim_cnt_q, decim_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          timeout_clr, timeout_inc, timeout_en, timeout_hit;
  logic          accept, trig;

  // new_sample is a single-cycle strobe with no back-pressure: every accepted
  // sample is consumed in the cycle it arrives, so back-to-back strobes are safe.
  assign accept      = new_sample && (decim_cnt_q == 8'd0);
  assign decim_cnt_d = (decim_cnt_q == D_LAST) ? 8'd0 : decim_cnt_q + 8'd1;

  dffre #(.W(8), .RST_VAL(8'd0)) u_decim_cnt (
    .clk (clk),
    .rst (reset),
    .en  (new_sample),
    .d   (decim_cnt_d),
    .q   (decim_cnt_q)
  );

  assign timeout_hit   = (TIMEOUT != 0) && (timeout_cnt_q == T_LAST);
  assign timeout_en    = timeout_clr || timeout_inc;
  assign timeout_cnt_d = timeout_clr ? '0 :
                         (timeout_cnt_q == T_LAST) ? timeout_cnt_q : timeout_cnt_q + 1'b1;

  dffre #(.W(TW), .RST_VAL('0)) u_timeout_cnt (
    .clk (clk),
    .rst (reset),
    .en  (timeout_en),
    .d   (timeout_cnt_d),
    .q   (timeout_cnt_q)
  );

  wave_trigger_detect #(.TRIG_LEVEL(TRIG_LEVEL)) u_trig (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .sample_in (sample_in),
    .trig      (trig)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    read_index_d = read_index_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    timeout_clr  = 1'b0;
    timeout_inc  = 1'b0;
    case (state_q)
      ST_ARMED: begin
        if (accept) begin
          if (trig || timeout_hit) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = {~read_index_q, 8'd0};
            wr_data_d   = sample_in;
            wr_ptr_d    = 8'd1;
            timeout_clr = 1'b1;
            state_d     = ST_ACTIVE;
          end else begin
            timeout_inc = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~read_index_q, wr_ptr_q};
          wr_data_d = sample_in;
          wr_ptr_d  = wr_ptr_q + 8'd1;
          if (wr_ptr_q == 8'hFF) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Only swap once the whole half is written; earlier vsyncs are ignored.
        if (vsync) begin
          read_index_d = ~read_index_q;
          state_d      = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
    frame_ready_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ARMED;
      wr_ptr_q      <= '0;
      read_index_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      read_index_q  <= read_index_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign read_index  = read_index_q;
  assign state       = state_q;
  assign frame_ready = frame_ready_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl: two instances (DECIM=1 and DECIM=4) share the
// stimulus and are compared every cycle against a capture-list reference model.
module tb_wave_capture_ctrl;

  localparam int TMO = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_sample = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       vsync = 1'b0;

  logic       wr_en_o [2];
  logic [8:0] wr_addr_o [2];
  logic [7:0] wr_data_o [2];
  logic       read_index_o [2];
  logic [1:0] state_o [2];
  logic       frame_ready_o [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: per instance, a phase (0 armed, 1 capturing, 2 full),
  // the number of samples captured so far and the displayed half.
  int m_dec [2] = '{1, 4};
  int m_scnt [2];
  int m_prev [2];
  int m_mode [2];
  int m_armed_n [2];
  int m_ncap [2];
  int m_rd [2];
  int exp_en [2];
  int exp_addr [2];
  int exp_data [2];

  always #5 clk = ~clk;

  wave_capture_ctrl #(.DECIM(1), .TRIG_LEVEL(8'd128), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample_in(sample_in),
    .vsync(vsync), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]), .wr_data(wr_data_o[0]),
    .read_index(read_index_o[0]), .state(state_o[0]), .frame_ready(frame_ready_o[0])
  );

  wave_capture_ctrl #(.DECIM(4), .TRIG_LEVEL(8'd128), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .reset(reset), .new_sample(new_sample), .sample_in(sample_in),
    .vsync(vsync), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]), .wr_data(wr_data_o[1]),
    .read_index(read_index_o[1]), .state(state_o[1]), .frame_ready(frame_ready_o[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scnt[k] = 0; m_prev[k] = 128; m_mode[k] = 0; m_armed_n[k] = 0;
      m_ncap[k] = 0; m_rd[k] = 0; exp_en[k] = 0; exp_addr[k] = 0; exp_data[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit ns, int s, bit vs);
    bit acc;
    bit capture;
    acc = ns && (m_scnt[k] == 0);
    if (ns) m_scnt[k] = (m_scnt[k] + 1) % m_dec[k];
    exp_en[k] = 0;
    capture = 0;
    if (m_mode[k] == 0 && acc) begin
      // Trigger on an upward crossing, or auto-trigger on the TMO-th sample since arming.
      if ((m_prev[k] < 128 && s >= 128) || (m_armed_n[k] + 1 == TMO)) begin
        m_mode[k] = 1; m_ncap[k] = 0; m_armed_n[k] = 0; capture = 1;
      end else begin
        m_armed_n[k]++;
      end
    end else if (m_mode[k] == 1 && acc) begin
      capture = 1;
    end else if (m_mode[k] == 2 && vs) begin
      m_rd[k] = 1 - m_rd[k]; m_mode[k] = 0; m_ncap[k] = 0;
    end
    if (capture) begin
      exp_en[k] = 1;
      exp_addr[k] = (1 - m_rd[k]) * 256 + m_ncap[k];
      exp_data[k] = s;
      m_ncap[k]++;
      if (m_ncap[k] == 256) m_mode[k] = 2;
    end
    if (acc) m_prev[k] = s;
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wr_en[%0d]", k), 32'(wr_en_o[k]), 32'(exp_en[k]));
      if (exp_en[k] != 0) begin
        chk($sformatf("wr_addr[%0d]", k), 32'(wr_addr_o[k]), 32'(exp_addr[k]));
        chk($sformatf("wr_data[%0d]", k), 32'(wr_data_o[k]), 32'(exp_data[k]));
      end
      chk($sformatf("read_index[%0d]", k), 32'(read_index_o[k]), 32'(m_rd[k]));
      chk($sformatf("frame_ready[%0d]", k), 32'(frame_ready_o[k]), 32'(m_mode[k] == 2));
      chk($sformatf("state[%0d]", k), 32'(state_o[k]), 32'(m_mode[k]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_wr_en"}, 32'(wr_en_o[k]), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr_o[k]), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data_o[k]), 32'd0);
      chk({tag, "_read_index"}, 32'(read_index_o[k]), 32'd0);
      chk({tag, "_state"}, 32'(state_o[k]), 32'd0);
      chk({tag, "_frame_ready"}, 32'(frame_ready_o[k]), 32'd0);
    end
  endtask

  task automatic drive(input bit ns, input int s, input bit vs);
    new_sample = ns; sample_in = 8'(s); vsync = vs;
    for (int k = 0; k < 2; k++) model_step(k, ns, s, vs);
    @(posedge clk);
    #1;
    check_outputs();
    new_sample = 1'b0; vsync = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values("reset");
  endtask

  // Ramp 100,110..200 repeating until instance 0 holds a full frame; also
  // fires vsync on the 256th-sample cycle and randomly while armed/capturing.
  task automatic ramp_capture(input string tag, input int first_addr);
    int  r;
    bit  seen;
    bit  vs;
    int  budget;
    r = 0; seen = 0; budget = 0;
    while (m_mode[0] != 2 && budget < 2000) begin
      vs = (m_mode[0] == 1 && m_ncap[0] == 255) ? 1'b1 : ($urandom_range(0, 7) == 0);
      drive(1'b1, 100 + 10 * (r % 11), vs);
      r++; budget++;
      if (!seen && wr_en_o[0]) begin
        seen = 1;
        chk({tag, "_first_data"}, 32'(wr_data_o[0]), 32'd130);
        chk({tag, "_first_addr"}, 32'(wr_addr_o[0]), 32'(first_addr));
      end
    end
    chk({tag, "_frame_full"}, 32'(frame_ready_o[0]), 32'd1);
  endtask

  initial begin
    int cnt4;
    int budget;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    ramp_capture("cap0", 9'h100);
    repeat (5) drive(1'b0, 0, 1'b0);
    chk("rd_hold_before_vsync", 32'(read_index_o[0]), 32'd0);
    drive(1'b0, 0, 1'b1);
    chk("rd_after_vsync", 32'(read_index_o[0]), 32'd1);
    ramp_capture("cap1", 9'h000);
    drive(1'b0, 0, 1'b1);
    chk("rd_after_vsync2", 32'(read_index_o[0]), 32'd0);

    // Auto-trigger: constant 50 never crosses the threshold.
    do_reset();
    for (int i = 0; i < TMO; i++) begin
      drive(1'b1, 50, 1'b0);
      if (i == TMO - 2) chk("tmo_still_armed", 32'(state_o[0]), 32'd0);
    end
    chk("tmo_state_active", 32'(state_o[0]), 32'd1);
    chk("tmo_wr_en", 32'(wr_en_o[0]), 32'd1);
    chk("tmo_wr_addr", 32'(wr_addr_o[0]), 32'h100);
    chk("tmo_wr_data", 32'(wr_data_o[0]), 32'd50);

    // DECIM=4 with strobes every cycle: crossing at strobe 4, last write at strobe 1024.
    do_reset();
    cnt4 = 0;
    drive(1'b1, 50, 1'b0);
    for (int i = 1; i <= 1024; i++) begin
      drive(1'b1, 200, 1'b0);
      if (wr_en_o[1]) cnt4++;
      if (i == 1023) begin
        chk("dec4_writes_1024", 32'(cnt4), 32'd255);
        chk("dec4_still_active", 32'(state_o[1]), 32'd1);
      end
    end
    chk("dec4_writes_1025", 32'(cnt4), 32'd256);
    chk("dec4_frame_ready", 32'(frame_ready_o[1]), 32'd1);

    // Reset in the middle of a capture, checked before the next clock edge.
    do_reset();
    budget = 0;
    while (!(m_mode[0] == 1 && m_ncap[0] == 100) && budget < 500) begin
      drive(1'b1, 100 + 10 * (budget % 11), 1'b0);
      budget++;
    end
    chk("mid_wr_en_before_reset", 32'(wr_en_o[0]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ramp_capture("cap_after_reset", 9'h100);

    // vsync coinciding with a sample in WAIT: swap, no write, prev updates to 200.
    drive(1'b1, 50, 1'b0);
    drive(1'b1, 200, 1'b1);
    chk("coinc_rd", 32'(read_index_o[0]), 32'd1);
    chk("coinc_wr_en", 32'(wr_en_o[0]), 32'd0);
    drive(1'b1, 150, 1'b0);
    chk("coinc_no_trig", 32'(state_o[0]), 32'd0);
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 150, 1'b0);
    chk("coinc_trig_state", 32'(state_o[0]), 32'd1);
    chk("coinc_trig_addr", 32'(wr_addr_o[0]), 32'h000);
    chk("coinc_trig_data", 32'(wr_data_o[0]), 32'd150);

    // Random traffic: sparse/dense strobes, random samples, random vsync.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
Ping-pong write-side controller for the 512x8 waveform sample RAM that the wave display reads. The RAM is split into two 256-entry halves by address bit 8. The display reads the half selected by read_index; this block fills the other half. It decimates incoming audio samples, waits for a rising trigger crossing (or an auto-trigger timeout), writes 256 consecutive samples, then swaps halves on the next vsync.

Parameters:
DECIM, 1, accept one of every DECIM new_sample strobes (1..255).
TRIG_LEVEL, 8'd128, unsigned trigger threshold.
TIMEOUT, 1024, accepted samples spent in ARMED before forcing a trigger (0 = auto-trigger disabled).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
new_sample  input  1  one-cycle strobe; sample_in valid
sample_in  input  8  unsigned sample (offset binary, 128 = zero)
vsync  input  1  one-cycle strobe at start of vertical blank
wr_en  output  1  RAM write enable (registered)
wr_addr  output  9  {~read_index, wr_ptr} (registered)
wr_data  output  8  sample to write (registered)
read_index  output  1  RAM half the display reads
state  output  2  current state (debug)
frame_ready  output  1  high while in WAIT (full capture pending swap)

Behaviour:
- Reset values (applied asynchronously): state=ARMED, read_index=0, wr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, frame_ready=0, prev_sample=TRIG_LEVEL, decim_cnt=0, timeout_cnt=0.
- Decimation:
  - decim_cnt increments on each new_sample and wraps at DECIM-1 to 0.
  - A sample is "accepted" when new_sample=1 and decim_cnt==0.
  - DECIM=1 accepts every strobe.
- prev_sample loads sample_in on every accepted sample, in every state.
- Trigger condition: prev_sample < TRIG_LEVEL and sample_in >= TRIG_LEVEL, using 8-bit unsigned compares.
- FSM, state encoding ARMED=0, ACTIVE=1, WAIT=2:
  - ARMED:
    - On an accepted sample with the trigger condition, or with timeout_cnt==TIMEOUT-1 (when TIMEOUT!=0): write that sample at wr_ptr=0, set wr_ptr=1, clear timeout_cnt, go to ACTIVE.
    - On any other accepted sample: timeout_cnt+1 (saturating).
  - ACTIVE:
    - Each accepted sample is written at wr_ptr and wr_ptr increments (8-bit).
    - The write at wr_ptr==255 wraps wr_ptr to 0 and moves to WAIT.
  - WAIT:
    - No writes; frame_ready=1.
    - On vsync: toggle read_index, go to ARMED.
- Write timing: wr_en pulses high for exactly one cycle, in the cycle after the accepted sample. wr_addr and wr_data are captured in that same edge. wr_addr[8] is the write half (~read_index) at acceptance time.
- Exactly 256 writes occur per capture, addresses 0..255 in order, all in the non-displayed half.
- Boundary conditions:
  - vsync in ARMED or ACTIVE is ignored; read_index never changes mid-capture.
  - vsync in the same cycle as the 256th accepted sample is ignored, because the FSM is not yet in WAIT. The swap happens on the next vsync.
  - new_sample and vsync may coincide in WAIT: swap occurs, the sample is not written, prev_sample still updates.
  - Back-to-back new_sample strobes (every cycle) must be sustained with no dropped writes.
  - Reset asserted mid-ACTIVE aborts the capture immediately. The partially written half is not displayed because read_index returns to 0; the next capture writes half 1.
  - wr_ptr and timeout_cnt never overflow into adjacent bits: wr_ptr is 8-bit wrap, timeout_cnt saturates at TIMEOUT-1.

Decomposition:
- Shared package wave_pkg: state encodings (ST_ARMED/ST_ACTIVE/ST_WAIT), RAM geometry constants (WAVE_HALF_AW=8, WAVE_AW=9, WAVE_DW=8), default TRIG_LEVEL.
- One natural sub-module: wave_trigger_detect. It holds prev_sample and produces the combinational trig flag from sample_in and the accepted-sample strobe.
- Decimation and timeout counters use the existing dffr/dffre flops, modified for async reset.

Test Plan:
- Reset, DECIM=1, ramp samples 100,110,...,200 on consecutive strobes:
  - First write is sample 130 (crossing 120->130) at wr_addr=9'h100.
  - 256 writes follow at 0x100..0x1FF, then frame_ready=1.
  - read_index stays 0 until vsync; then read_index=1 and the next capture writes 0x000..0x0FF.
- DECIM=4, strobes every cycle: wr_en pulses once per 4 strobes; 256 writes take 1024 strobes.
- Constant input 50 with TIMEOUT=1024:
  - No trigger for 1023 accepted samples.
  - The 1024th accepted sample auto-triggers, is written at address 0x100, and the state goes to ACTIVE.
- vsync pulses during ARMED/ACTIVE and on the 256th-sample cycle: read_index unchanged; the swap occurs only on the first vsync after frame_ready=1.
- Reset asserted after 100 writes of a capture: all outputs go to reset values asynchronously (before the next clk edge); the next capture starts at wr_addr=0x100.
- vsync and new_sample coincide in WAIT: read_index toggles, wr_en stays 0, and the following crossing triggers correctly using the updated prev_sample.
